// File: rtl/intc_hwint_if.sv
// Bridge-side and interrupt-side signals of the six-source interrupt controller.
// The bridge/bench drives through the master modport; intc_hwint is the slave.
interface intc_hwint_if;
    logic [5:0]  Src;
    logic        Sel;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic [5:0]  HWIntOut;
    logic        Irq;

    modport master (
        output Src, Sel, Addr, WE, DIn,
        input  DOut, HWIntOut, Irq
    );

    modport slave (
        input  Src, Sel, Addr, WE, DIn,
        output DOut, HWIntOut, Irq
    );
endinterface

// File: rtl/intc_hwint.sv
// Six-source interrupt controller feeding CP0 HWInt: pending/mask/mode/claim registers.
// Optional feature macro INTC_EDGE_DETECT_EN adds per-source edge mode (MODE reg + Prev).
module intc_hwint #(
    parameter int NSRC = 6
) (
    input logic         clk,
    input logic         rst,
    intc_hwint_if.slave bus
);

    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] set_cond;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] hw;
    logic            wr_en;
    logic [2:0]      claim_id;
    logic            unused_din;

    // Source index k as a one-hot clear vector; k >= NSRC matches no bit and is ignored.
    function automatic logic [NSRC-1:0] claim_decode(input logic [2:0] k);
        logic [NSRC-1:0] onehot;
        onehot = '0;
        for (int i = 0; i < NSRC; i++) begin
            onehot[i] = (k == 3'(i));
        end
        return onehot;
    endfunction

    assign wr_en      = bus.Sel & bus.WE;
    assign unused_din = ^bus.DIn[31:NSRC];

`ifdef INTC_EDGE_DETECT_EN
    logic [NSRC-1:0] prev;

    // Level sources pend while high; edge sources only on a low-to-high step.
    assign set_cond = bus.Src & (~mode | ~prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            mode <= '0;
        end else begin
            prev <= bus.Src;
            if (wr_en && bus.Addr == 2'd2) begin
                mode <= bus.DIn[NSRC-1:0];
            end
        end
    end
`else
    assign set_cond = bus.Src;
    assign mode     = '0;
`endif

    always_comb begin
        clr = '0;
        if (wr_en && bus.Addr == 2'd0) begin
            clr = bus.DIn[NSRC-1:0];
        end else if (wr_en && bus.Addr == 2'd3) begin
            clr = claim_decode(bus.DIn[2:0]);
        end
    end

    // A set in the same cycle as a clear wins, so a live level source re-pends at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            mask <= '0;
        end else begin
            pend <= (pend & ~clr) | set_cond;
            if (wr_en && bus.Addr == 2'd1) begin
                mask <= bus.DIn[NSRC-1:0];
            end
        end
    end

    assign hw           = pend & mask;
    assign bus.HWIntOut = hw;
    assign bus.Irq      = |hw;

    // Index 0 has the highest priority, so scan downwards and let the lowest hit stick.
    always_comb begin
        claim_id = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (hw[i]) begin
                claim_id = 3'(i);
            end
        end
    end

    always_comb begin
        bus.DOut = '0;
        if (bus.Sel) begin
            case (bus.Addr)
                2'd0: bus.DOut = {{(32 - NSRC){1'b0}}, pend};
                2'd1: bus.DOut = {{(32 - NSRC){1'b0}}, mask};
                2'd2: bus.DOut = {{(32 - NSRC){1'b0}}, mode};
                2'd3: bus.DOut = {bus.Irq, 28'b0, claim_id};
                default: bus.DOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_intc_hwint.sv
// Bench for intc_hwint: directed scenarios plus randomized traffic against a
// per-source behavioural model of the pending/mask/mode/claim rules.
module tb_intc_hwint;

`ifdef INTC_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    intc_hwint_if bus();

    intc_hwint dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    bit [5:0] m_pend, m_mask, m_mode, m_prev;

    // Apply the register rules for one clock edge using the inputs the bench is driving.
    function automatic void model_step();
        bit [5:0] np;
        bit       set_b, clr_b;
        if (rst) begin
            m_pend = '0; m_mask = '0; m_mode = '0; m_prev = '0;
            return;
        end
        for (int i = 0; i < 6; i++) begin
            if (EDGE && m_mode[i]) set_b = bus.Src[i] && !m_prev[i];
            else                   set_b = bus.Src[i];
            clr_b = bus.Sel && bus.WE &&
                    ((bus.Addr == 2'd0 && bus.DIn[i]) ||
                     (bus.Addr == 2'd3 && int'(bus.DIn[2:0]) == i));
            np[i] = set_b ? 1'b1 : (clr_b ? 1'b0 : m_pend[i]);
        end
        if (bus.Sel && bus.WE && bus.Addr == 2'd1) m_mask = bus.DIn[5:0];
        if (EDGE && bus.Sel && bus.WE && bus.Addr == 2'd2) m_mode = bus.DIn[5:0];
        m_prev = bus.Src;
        m_pend = np;
    endfunction

    function automatic logic [31:0] exp_read(input logic sel, input logic [1:0] addr);
        bit [5:0]    act;
        bit          found;
        logic [31:0] r;
        act = m_pend & m_mask;
        r = 32'h0;
        found = 1'b0;
        if (sel) begin
            case (addr)
                2'd0: r = {26'b0, m_pend};
                2'd1: r = {26'b0, m_mask};
                2'd2: r = {26'b0, m_mode};
                default: begin
                    for (int i = 0; i < 6; i++) begin
                        if (act[i] && !found) begin
                            r = {1'b1, 28'b0, 3'(i)};
                            found = 1'b1;
                        end
                    end
                end
            endcase
        end
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.Sel = 1'b1; bus.WE = 1'b1; bus.Addr = a; bus.DIn = d;
        cycle();
        bus.Sel = 1'b0; bus.WE = 1'b0; bus.DIn = 32'h0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.Sel = 1'b1; bus.WE = 1'b0; bus.Addr = a;
        #1;
        d = bus.DOut;
        bus.Sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        bus.Src = '0; bus.Sel = 1'b0; bus.WE = 1'b0; bus.Addr = '0; bus.DIn = '0;
        cycle();
        cycle();
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            vectors++;
            if (d !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_read[%0d]: got %h expected %h", a, d, 32'h0);
            end
        end
        vectors++;
        if (bus.HWIntOut !== 6'h0 || bus.Irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hwint: got %b/%b expected 000000/0", bus.HWIntOut, bus.Irq);
        end
    endtask

    task automatic test_level();
        logic [31:0] d;
        wr(2'd1, 32'h3F);
        wr(2'd2, 32'h0);
        bus.Src = 6'h08;
        cycle();
        vectors++;
        if (bus.HWIntOut !== 6'b001000) begin
            miscompares++;
            $display("FAIL level_hwint: got %b expected %b", bus.HWIntOut, 6'b001000);
        end
        rd(2'd3, d);
        vectors++;
        if (d !== 32'h8000_0003) begin
            miscompares++;
            $display("FAIL level_claim: got %h expected %h", d, 32'h8000_0003);
        end
        wr(2'd0, 32'h08);
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h08) begin
            miscompares++;
            $display("FAIL level_set_wins: got %h expected %h", d, 32'h08);
        end
        bus.Src = 6'h00;
        wr(2'd0, 32'h08);
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL level_clear: got %h expected %h", d, 32'h0);
        end
    endtask

    task automatic test_edge();
        logic [31:0] d;
        wr(2'd2, 32'h3F);
        wr(2'd1, 32'h3F);
        rd(2'd2, d);
        vectors++;
        if (d !== (EDGE ? 32'h3F : 32'h0)) begin
            miscompares++;
            $display("FAIL mode_read: got %h expected %h", d, EDGE ? 32'h3F : 32'h0);
        end
        bus.Src = 6'h02;
        cycle();
        bus.Src = 6'h00;
        cycle();
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h02) begin
            miscompares++;
            $display("FAIL pulse_capture: got %h expected %h", d, 32'h02);
        end
        wr(2'd3, 32'h1);
        cycle();
        cycle();
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL pulse_claim_clear: got %h expected %h", d, 32'h0);
        end
        bus.Src = 6'h02;
        cycle();
        cycle();
        wr(2'd3, 32'h1);
        rd(2'd0, d);
        vectors++;
        if (d !== (EDGE ? 32'h0 : 32'h02)) begin
            miscompares++;
            $display("FAIL held_src_claim: got %h expected %h", d, EDGE ? 32'h0 : 32'h02);
        end
        bus.Src = 6'h00;
        wr(2'd0, 32'h3F);
    endtask

    task automatic test_mask();
        logic [31:0] d;
        wr(2'd1, 32'h00);
        bus.Src = 6'h20;
        cycle();
        bus.Src = 6'h00;
        cycle();
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h20) begin
            miscompares++;
            $display("FAIL masked_pend: got %h expected %h", d, 32'h20);
        end
        vectors++;
        if (bus.Irq !== 1'b0 || bus.HWIntOut !== 6'h0) begin
            miscompares++;
            $display("FAIL masked_irq: got %b/%b expected 0/000000", bus.Irq, bus.HWIntOut);
        end
        rd(2'd3, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL masked_claim: got %h expected %h", d, 32'h0);
        end
        wr(2'd1, 32'h20);
        vectors++;
        if (bus.HWIntOut !== 6'b100000 || bus.Irq !== 1'b1) begin
            miscompares++;
            $display("FAIL unmask_hwint: got %b/%b expected 100000/1", bus.HWIntOut, bus.Irq);
        end
        rd(2'd3, d);
        vectors++;
        if (d !== 32'h8000_0005) begin
            miscompares++;
            $display("FAIL unmask_claim: got %h expected %h", d, 32'h8000_0005);
        end
        wr(2'd0, 32'h20);
    endtask

    task automatic test_priority();
        logic [31:0] d;
        wr(2'd1, 32'h3F);
        bus.Src = 6'h14;
        cycle();
        bus.Src = 6'h00;
        cycle();
        rd(2'd3, d);
        vectors++;
        if (d !== 32'h8000_0002) begin
            miscompares++;
            $display("FAIL prio_claim: got %h expected %h", d, 32'h8000_0002);
        end
        wr(2'd3, 32'h2);
        rd(2'd3, d);
        vectors++;
        if (d !== 32'h8000_0004) begin
            miscompares++;
            $display("FAIL prio_retire: got %h expected %h", d, 32'h8000_0004);
        end
        wr(2'd3, 32'h7);
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h10) begin
            miscompares++;
            $display("FAIL claim_k7_ignored: got %h expected %h", d, 32'h10);
        end
        bus.Sel = 1'b0; bus.WE = 1'b0; bus.Addr = 2'd0;
        #1;
        vectors++;
        if (bus.DOut !== 32'h0) begin
            miscompares++;
            $display("FAIL unmapped_read: got %h expected %h", bus.DOut, 32'h0);
        end
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, d);
        vectors++;
        if (d !== 32'h3F) begin
            miscompares++;
            $display("FAIL mask_upper_bits: got %h expected %h", d, 32'h3F);
        end
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL pend_w1c_all: got %h expected %h", d, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(2'd1, 32'h3F);
        wr(2'd2, 32'h3F);
        bus.Src = 6'h00;
        cycle();
        rst = 1'b1;
        bus.Sel = 1'b1; bus.WE = 1'b1; bus.Addr = 2'd1; bus.DIn = 32'h3F;
        bus.Src = 6'h01;
        cycle();
        rst = 1'b0;
        bus.Sel = 1'b0; bus.WE = 1'b0; bus.DIn = 32'h0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            vectors++;
            if (d !== 32'h0) begin
                miscompares++;
                $display("FAIL midreset_read[%0d]: got %h expected %h", a, d, 32'h0);
            end
        end
        vectors++;
        if (bus.HWIntOut !== 6'h0) begin
            miscompares++;
            $display("FAIL midreset_hwint: got %b expected %b", bus.HWIntOut, 6'h0);
        end
        cycle();
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h01) begin
            miscompares++;
            $display("FAIL post_reset_pend: got %h expected %h", d, 32'h01);
        end
        bus.Src = 6'h00;
        wr(2'd0, 32'h3F);
    endtask

    task automatic test_random();
        logic [31:0] e;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bus.Src  = 6'($urandom & $urandom);
            bus.Sel  = ($urandom_range(0, 7) != 0);
            bus.WE   = ($urandom_range(0, 3) == 0);
            bus.Addr = 2'($urandom);
            bus.DIn  = $urandom;
            #1;
            e = exp_read(bus.Sel, bus.Addr);
            vectors++;
            if (bus.DOut !== e || bus.HWIntOut !== (m_pend & m_mask) ||
                bus.Irq !== |(m_pend & m_mask)) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h/%b/%b expected %h/%b/%b", n,
                         bus.DOut, bus.HWIntOut, bus.Irq, e, m_pend & m_mask, |(m_pend & m_mask));
            end
            cycle();
        end
        bus.Sel = 1'b0; bus.WE = 1'b0; bus.Src = 6'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_mask();
        test_priority();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intc_hwint.md
# intc_hwint

Six-source interrupt controller sitting between peripherals and CP0's `HWInt[5:0]` input. It latches interrupt requests into a pending register, applies a software mask and produces the aggregated `HWInt` vector. It also exposes a priority claim register so the exception handler can identify and retire one source per access. The block is memory-mapped through the system bridge at 0x0000_7F20–0x0000_7F2F, alongside Timer0 (0x7F00) and Timer1 (0x7F10).

## Interface
Parameters:
- `NSRC`, 6: number of interrupt sources; fixed to CP0 `HWInt` width, not to be overridden.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `Src`  in  6  peripheral interrupt requests, already synchronous to `clk`
- `Sel`  in  1  bridge chip-select; the bridge decodes `Addr[31:4]==28'h0000_7F2`
- `Addr`  in  2  word offset, `Addr[3:2]` of the byte address
- `WE`  in  1  write enable; effective only when `Sel`=1
- `DIn`  in  32  write data
- `DOut`  out  32  read data, combinational from `Addr`
- `HWIntOut`  out  6  `PEND & MASK`, wired to CP0 `HWInt`
- `Irq`  out  1  OR-reduction of `HWIntOut`

## Operation
- Registers, by word offset:
  - 0 PEND: read; write-1-to-clear on bits [5:0].
  - 1 MASK: read/write [5:0].
  - 2 MODE: read/write [5:0]; 1 = edge, 0 = level.
  - 3 CLAIM: read returns `{valid, 28'b0, id[2:0]}`; a write retires a source.
- Bits [31:6] of PEND, MASK and MODE read 0. Writes to those bits are ignored.
- `Prev[5:0]` is `Src` registered every cycle. It is used for edge detection.
- Per-bit pending set condition:
  - Edge mode: `Src[i] & ~Prev[i]`.
  - Level mode: `Src[i]`.
- Pending bits are sticky until cleared by a PEND W1C write or a CLAIM write.
- Set/clear priority: if a bit's set condition and its clear occur in the same cycle, the set wins and the bit stays 1.
  - Consequence: a level source still asserted is re-pended immediately after a clear.
- CLAIM read:
  - `id` = lowest index i with `PEND[i]&MASK[i]`; index 0 has the highest priority.
  - `valid` = `Irq`.
  - When none is pending, CLAIM reads 0x0000_0000.
  - The read has no side effects.
- CLAIM write: `DIn[2:0]`=k with k<6 clears `PEND[k]`, subject to the set-wins rule. k≥6 is ignored.
- MASK does not gate latching. A masked source still pends and appears on `HWIntOut` as soon as it is unmasked.
- Unmapped reads (`Sel`=0) return 0.

## Timing
- Reset values: PEND, MASK, MODE and Prev = 0. Consequently `HWIntOut`=0, `Irq`=0, and `DOut`=0 for every offset.
- Latency:
  - `Src` edge at cycle n → PEND set at posedge n+1 → `HWIntOut` high in cycle n+1.
  - CP0 registers `IP` one cycle later.
- Register writes take effect at the posedge where `Sel&WE` is high. `DOut` reflects the new value in the following cycle.
- `DOut` and `HWIntOut` are purely combinational from registers and `Addr`. There is no combinational path from `Src`.
- Reset mid-operation: all state clears on that posedge regardless of `WE` or `Src`. Prev also clears, so a `Src` held high in edge mode produces an edge on the first cycle after reset.
- Edge pulses of a single cycle are captured. Two rising edges before a clear coalesce into one pending bit.

## Configuration
- `INTC_EDGE_DETECT_EN` defined:
  - MODE register and Prev are implemented as described above.
- Not defined:
  - All sources are level-sensitive.
  - MODE reads 0 and writes are ignored.
  - Prev is removed.
  - All other behaviour is identical.

## Test plan
- Reset, then read all four offsets → all 0x0000_0000; `HWIntOut`=6'b0.
- MASK=0x3F, MODE=0 (level); hold `Src[3]`=1 → next cycle `HWIntOut`=6'b001000 and CLAIM=0x8000_0003. Write PEND=0x08 while `Src[3]` is still high → PEND stays 0x08. Drop `Src[3]`, then write PEND=0x08 → PEND=0.
- MODE=0x3F, MASK=0x3F; 1-cycle pulse on `Src[1]` → PEND=0x02 after it falls. Write CLAIM=1 → PEND=0; no re-pend.
- MASK=0x00; pulse `Src[5]` → PEND=0x20, `Irq`=0, CLAIM=0. Write MASK=0x20 → next cycle `HWIntOut`=6'b100000 and CLAIM=0x8000_0005.
- `Src[2]` and `Src[4]` pend together → CLAIM id=2. Write CLAIM=2 → CLAIM=0x8000_0004. Write CLAIM=7 → no change.
- Assert `rst` in the same cycle as `WE`, MASK=0x3F and a rising `Src[0]` → all registers 0 next cycle. With `INTC_EDGE_DETECT_EN` undefined, write MODE=0x3F → MODE reads 0.
